// File: rtl/pll_lock_sequencer.sv
// PLL reset and lock supervisor on the free-running reference clock: pulses the PLL
// reset, qualifies lock over a stability window and gates the transceiver reset.
module pll_lock_sequencer #(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int LOSS_FILTER    = 4
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       xcvr_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] relock_count,
  output logic [7:0] timeout_count
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LOSS_LAST    = CW'(LOSS_FILTER - 1);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    READY     = 2'd3
  } state_t;

  state_t        st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sync1, locked_s;
  logic          relock_inc, timeout_inc;

  // pll_locked comes from the PLL domain; two flops before it is used
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  always_comb begin
    st_nxt      = st;
    cnt_nxt     = cnt;
    relock_inc  = 1'b0;
    timeout_inc = 1'b0;
    if (restart) begin
      st_nxt  = PLL_RESET;
      cnt_nxt = '0;
    end else begin
      case (st)
        PLL_RESET: begin
          if (cnt == RST_LAST) begin
            st_nxt  = WAIT_LOCK;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            st_nxt  = STABLE;
            cnt_nxt = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            st_nxt      = PLL_RESET;
            cnt_nxt     = '0;
            timeout_inc = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        STABLE: begin
          // a dropout restarts the whole timeout window, not just the stability run
          if (!locked_s) begin
            st_nxt  = WAIT_LOCK;
            cnt_nxt = '0;
          end else if (cnt == STABLE_LAST) begin
            st_nxt  = READY;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        READY: begin
          if (locked_s) begin
            cnt_nxt = '0;
          end else if (cnt == LOSS_LAST) begin
            st_nxt     = PLL_RESET;
            cnt_nxt    = '0;
            relock_inc = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          st_nxt  = PLL_RESET;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= PLL_RESET;
      cnt           <= '0;
      relock_count  <= 8'd0;
      timeout_count <= 8'd0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      if (relock_inc && relock_count != 8'hFF)
        relock_count <= relock_count + 8'd1;
      if (timeout_inc && timeout_count != 8'hFF)
        timeout_count <= timeout_count + 8'd1;
    end
  end

  assign state    = st;
  assign pll_rst  = (st == PLL_RESET);
  assign xcvr_rst = (st != READY);
  assign ready    = (st == READY);

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Reset and lock supervisor for the transceiver clock PLL. It holds the PLL in reset at power-up and qualifies the PLL `locked` flag over a stability window. It releases the downstream transceiver logic from reset only while lock is qualified, and re-runs the sequence on timeout, loss of lock or a software restart. It runs on the free-running 25 MHz board reference, so it keeps supervising when the PLL output clock stops.

## Interface
Parameters:
- `RST_CYCLES`, 16: refclk cycles `pll_rst` is held high per reset pulse (≥2).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release (≥2).
- `TIMEOUT_CYCLES`, 65536: maximum cycles in WAIT_LOCK before the PLL is re-reset. Must be ≥ `STABLE_CYCLES` and ≥ `RST_CYCLES`.
- `LOSS_FILTER`, 4: consecutive unlocked cycles in READY that count as loss of lock (≥1).

Ports:
- `refclk`, in, 1: 25 MHz reference clock; the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pll_locked`, in, 1: PLL lock flag; asynchronous to `refclk`.
- `restart`, in, 1: synchronous single-cycle request to restart the sequence.
- `pll_rst`, out, 1: active-high reset to the PLL `rst` input.
- `xcvr_rst`, out, 1: active-high reset to transceiver logic.
- `ready`, out, 1: lock qualified; transceiver logic released.
- `state`, out, 2: current state. PLL_RESET=0, WAIT_LOCK=1, STABLE=2, READY=3.
- `relock_count`, out, 8: loss-of-lock events; saturating.
- `timeout_count`, out, 8: lock timeouts; saturating.

## Operation
- `pll_locked` passes through a 2-FF synchronizer (both FFs reset to 0) to give `locked_s`.
- One shared cycle counter `cnt`, wide enough for `TIMEOUT_CYCLES-1`. It is cleared on every state transition.
- Outputs are Moore decodes of the registered state: `pll_rst` = (state==PLL_RESET), `xcvr_rst` = (state!=READY), `ready` = (state==READY).
- **PLL_RESET**: `cnt` increments each cycle. When `cnt==RST_CYCLES-1`, go to WAIT_LOCK.
- **WAIT_LOCK**:
  - If `locked_s`=1, go to STABLE.
  - Otherwise, when `cnt==TIMEOUT_CYCLES-1`, go to PLL_RESET and increment `timeout_count`.
  - Otherwise increment `cnt`.
- **STABLE**:
  - If `locked_s`=0, go to WAIT_LOCK. This is not counted as an event, and the timeout window restarts.
  - Otherwise, when `cnt==STABLE_CYCLES-1`, go to READY.
  - Otherwise increment `cnt`.
- **READY**:
  - `cnt` counts consecutive cycles with `locked_s`=0, and is cleared on any cycle with `locked_s`=1.
  - When an unlocked cycle occurs with `cnt==LOSS_FILTER-1`, go to PLL_RESET and increment `relock_count`.
- **restart**: when `restart`=1 in any state, the next state is PLL_RESET with `cnt` cleared.
  - This has priority over every other transition.
  - No event counter increments on that cycle, even if a timeout or loss would otherwise fire.
  - `restart` during PLL_RESET restarts the full `RST_CYCLES` pulse.
- Both event counters saturate at 255. They clear only on `rst_n`.

## Timing
- **Reset values** (while `rst_n`=0): state=PLL_RESET, `cnt`=0, sync FFs=0, `pll_rst`=1, `xcvr_rst`=1, `ready`=0, `relock_count`=0, `timeout_count`=0.
- **Reset assertion mid-operation**: asserting `rst_n` at any point forces the reset values immediately (asynchronous). Deassertion is sampled on the next `refclk` rising edge.
- **Lock path latency**: 2 cycles from `pll_locked` to `locked_s`, plus 1 cycle for the state update.
- **Startup with `pll_locked` held high**:
  - State enters WAIT_LOCK after edge `RST_CYCLES` (16).
  - State enters STABLE after edge 17.
  - `ready` rises and `xcvr_rst` falls after edge 17+`STABLE_CYCLES` = 1041.
- **Loss of lock**: `pll_locked` falling in READY raises `pll_rst` and `xcvr_rst` after 2+`LOSS_FILTER` = 6 edges.
  - A low glitch shorter than `LOSS_FILTER` cycles after synchronization has no effect.
- **Timeout**: with `pll_locked`=0, WAIT_LOCK lasts exactly `TIMEOUT_CYCLES` cycles. `timeout_count` increments on the same edge that re-enters PLL_RESET.

## Test plan
- **Startup**: release `rst_n` with `pll_locked`=1.
  - Expect `pll_rst` high for 16 cycles and `state` 0→1→2→3.
  - Expect `ready`=1 and `xcvr_rst`=0 after edge 1041; both counters stay 0.
- **Glitch and loss**: in READY, pulse `pll_locked` low for 3 cycles, then for 4 cycles.
  - The 3-cycle glitch causes no change.
  - The 4-cycle drop returns state to 0 after 6 edges, sets `relock_count`=1, and `ready` falls.
- **Timeout**: with `TIMEOUT_CYCLES`=64 and `pll_locked`=0, run 3 full windows.
  - Expect `timeout_count`=3, a `pll_rst` pulse of 16 cycles between each 64-cycle WAIT_LOCK.
  - Force 260 timeouts and expect `timeout_count` to saturate at 255.
- **Stability abort**: drop `pll_locked` for 1 cycle at STABLE `cnt`=500.
  - Expect STABLE→WAIT_LOCK with no counter change.
  - After relock, a full 1024-cycle STABLE window is required before `ready`.
- **Restart**: assert `restart` on the same cycle a loss-of-lock transition would fire.
  - Expect state=0, `relock_count` unchanged, `pll_rst` high for 16 cycles.
  - Assert `restart` again at PLL_RESET `cnt`=10 and expect the 16-cycle count to restart.
- **Async reset**: assert `rst_n` mid-STABLE.
  - Expect all outputs at reset values without a clock edge, and the counters cleared.
